// File: rtl/fft_8_input_loader_if.sv
// Sample-stream and frame-output bundle for the 8-point FFT input loader.
// slave modport is the loader's view; master modport is the surrounding logic's view.
interface fft_8_input_loader_if #(
  parameter int N = 4
);
  localparam int DATA_W = 2**N;

  logic              s_valid;
  logic              s_ready;
  logic              s_first;
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] s_i;

  logic [DATA_W-1:0] out_0_r, out_1_r, out_2_r, out_3_r;
  logic [DATA_W-1:0] out_4_r, out_5_r, out_6_r, out_7_r;
  logic [DATA_W-1:0] out_0_i, out_1_i, out_2_i, out_3_i;
  logic [DATA_W-1:0] out_4_i, out_5_i, out_6_i, out_7_i;
  logic              out_valid;
  logic              out_ready;
  logic              resync_err;

  modport slave (
    input  s_valid, s_first, s_r, s_i, out_ready,
    output s_ready, out_valid, resync_err,
    output out_0_r, out_1_r, out_2_r, out_3_r, out_4_r, out_5_r, out_6_r, out_7_r,
    output out_0_i, out_1_i, out_2_i, out_3_i, out_4_i, out_5_i, out_6_i, out_7_i
  );

  modport master (
    output s_valid, s_first, s_r, s_i, out_ready,
    input  s_ready, out_valid, resync_err,
    input  out_0_r, out_1_r, out_2_r, out_3_r, out_4_r, out_5_r, out_6_r, out_7_r,
    input  out_0_i, out_1_i, out_2_i, out_3_i, out_4_i, out_5_i, out_6_i, out_7_i
  );
endinterface

// File: rtl/fft_8_input_loader.sv
// Serial-to-parallel frame loader feeding the 8-point FFT core.
// Collects 8 complex samples into a buffer while the previous frame is held
// on the registered out_* bus. Define FFT_LOADER_BITREV_EN to place stream
// sample k at out_{bitrev(k)} instead of out_k.
module fft_8_input_loader #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_8_input_loader_if.slave   bus
);
  localparam int DATA_W = 2**N;

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                   state;
  logic [2:0]               cnt;
  logic signed [DATA_W-1:0] sbuf_r [8];
  logic signed [DATA_W-1:0] sbuf_i [8];
  logic signed [DATA_W-1:0] out_r  [8];
  logic signed [DATA_W-1:0] out_i  [8];
  logic                     out_valid_q;
  logic                     resync_q;

  logic       accept;
  logic       slot_free;
  logic [2:0] idx;
  logic [2:0] wr_slot;
  logic       load_c;
  logic       load_f;

  function automatic logic [2:0] slot(input logic [2:0] k);
`ifdef FFT_LOADER_BITREV_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  // Accept/index decode; s_first forces the sample to index 0
  always_comb begin
    accept    = bus.s_valid && (state == COLLECT);
    slot_free = !out_valid_q || bus.out_ready;
    idx       = bus.s_first ? 3'd0 : cnt;
    wr_slot   = slot(idx);
    load_c    = accept && (idx == 3'd7) && slot_free;
    load_f    = (state == FULL) && slot_free;
  end

  // Collection buffer: data only, no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      sbuf_r[wr_slot] <= bus.s_r;
      sbuf_i[wr_slot] <= bus.s_i;
    end
  end

  // Frame FSM, output register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= 3'd0;
      out_valid_q <= 1'b0;
      resync_q    <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        out_r[j] <= '0;
        out_i[j] <= '0;
      end
    end else begin
      resync_q <= accept && bus.s_first && (cnt != 3'd0);
      if (accept) cnt <= idx + 3'd1;

      case (state)
        COLLECT: if (accept && (idx == 3'd7) && !slot_free) state <= FULL;
        FULL:    if (slot_free) state <= COLLECT;
        default: state <= COLLECT;
      endcase

      // slot(7) is 7 in both orderings, so the final sample bypasses the buffer there
      if (load_c || load_f) begin
        for (int j = 0; j < 8; j++) begin
          out_r[j] <= (load_c && j == 7) ? bus.s_r : sbuf_r[j];
          out_i[j] <= (load_c && j == 7) ? bus.s_i : sbuf_i[j];
        end
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready    = (state == COLLECT);
  assign bus.out_valid  = out_valid_q;
  assign bus.resync_err = resync_q;

  assign bus.out_0_r = out_r[0];
  assign bus.out_1_r = out_r[1];
  assign bus.out_2_r = out_r[2];
  assign bus.out_3_r = out_r[3];
  assign bus.out_4_r = out_r[4];
  assign bus.out_5_r = out_r[5];
  assign bus.out_6_r = out_r[6];
  assign bus.out_7_r = out_r[7];
  assign bus.out_0_i = out_i[0];
  assign bus.out_1_i = out_i[1];
  assign bus.out_2_i = out_i[2];
  assign bus.out_3_i = out_i[3];
  assign bus.out_4_i = out_i[4];
  assign bus.out_5_i = out_i[5];
  assign bus.out_6_i = out_i[6];
  assign bus.out_7_i = out_i[7];
endmodule
